// File: rtl/capture_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : capture_mem_ctrl
// Brief    : ADC capture-memory controller (one-shot / ring+trigger) with
//            oldest-first valid/ready readout. Optional: CAPTURE_DECIM_EN.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module capture_mem_ctrl #(
  parameter int NUM_CH = 96,
  parameter int DATA_W = 9,
  parameter int ADDR_W = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_mode,
  input  logic [ADDR_W:0]            cfg_post_cnt,
`ifdef CAPTURE_DECIM_EN
  input  logic [7:0]                 cfg_decim,
`endif
  input  logic                       start,
  input  logic                       abort,
  input  logic                       trig,
  input  logic                       adc_valid,
  input  logic [NUM_CH*DATA_W-1:0]   adc_data,
  input  logic                       rd_start,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [NUM_CH*DATA_W-1:0]   rd_data,
  output logic                       rd_last,
  output logic                       busy,
  output logic                       done,
  output logic                       wrapped,
  output logic [ADDR_W:0]            sample_cnt,
  output logic [NUM_CH-1:0]          mem_cen,
  output logic [NUM_CH-1:0]          mem_wen,
  output logic [NUM_CH*ADDR_W-1:0]   mem_addr,
  output logic [NUM_CH*DATA_W-1:0]   mem_wdata,
  input  logic [NUM_CH*DATA_W-1:0]   mem_rdata
);

  localparam logic [ADDR_W:0]   DEPTH_W   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   ONE_W     = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPT    = 3'd1,
    S_POST    = 3'd2,
    S_DONE    = 3'd3,
    S_RD_REQ  = 3'd4,
    S_RD_WAIT = 3'd5,
    S_RD_OUT  = 3'd6
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   post_rem;
  logic [ADDR_W:0]   rd_rem;
  // One-shot fill: wr_ptr has rolled back to 0 but every word is valid.
  logic              full;

  logic              in_capt;
  logic              keep;
  logic              act;
  logic              wr_en;
  logic              rd_req;
  logic              ring_wr;
  logic [ADDR_W:0]   post_clamped;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] addr_sel;

`ifdef CAPTURE_DECIM_EN
  logic [7:0]        decim_cnt;
  assign keep = (decim_cnt == 8'd0);
`else
  assign keep = 1'b1;
`endif

  assign in_capt      = (state == S_CAPT) || (state == S_POST);
  assign act          = !rst && !abort;
  assign wr_en        = act && in_capt && adc_valid && keep;
  assign rd_req       = act && (state == S_RD_REQ);
  assign ring_wr      = cfg_mode || (state == S_POST);
  assign post_clamped = (cfg_post_cnt > DEPTH_W) ? DEPTH_W : cfg_post_cnt;

  assign busy       = in_capt || (state == S_RD_REQ) || (state == S_RD_WAIT) ||
                      (state == S_RD_OUT);
  assign done       = (state == S_DONE);
  assign sample_cnt = (wrapped || full) ? DEPTH_W : {1'b0, wr_ptr};

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    addr_sel = '0;
    if (wr_en) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      addr_sel = wr_ptr;
    end else if (rd_req) begin
      mem_en   = 1'b1;
      addr_sel = rd_ptr;
    end
  end

  assign mem_cen   = {NUM_CH{~mem_en}};
  assign mem_wen   = {NUM_CH{~mem_we}};
  assign mem_wdata = wr_en ? adc_data : '0;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_addr
      assign mem_addr[g*ADDR_W +: ADDR_W] = addr_sel;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      post_rem <= '0;
      rd_rem   <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
      wrapped  <= 1'b0;
      full     <= 1'b0;
`ifdef CAPTURE_DECIM_EN
      decim_cnt <= 8'd0;
`endif
    end else if (abort) begin
      state    <= S_IDLE;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
`ifdef CAPTURE_DECIM_EN
      if (in_capt && adc_valid)
        decim_cnt <= (decim_cnt >= cfg_decim) ? 8'd0 : decim_cnt + 8'd1;
`endif
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_ptr == LAST_ADDR) begin
          if (ring_wr) wrapped <= 1'b1;
          else         full    <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_CAPT;
            wr_ptr  <= '0;
            wrapped <= 1'b0;
            full    <= 1'b0;
`ifdef CAPTURE_DECIM_EN
            decim_cnt <= 8'd0;
`endif
          end
        end
        S_CAPT: begin
          if (wr_en && !cfg_mode && (wr_ptr == LAST_ADDR)) begin
            state <= S_DONE;
          end else if (trig && cfg_mode) begin
            // A sample written alongside trig is still a pre-trigger sample.
            if (post_clamped == '0) begin
              state <= S_DONE;
            end else begin
              state    <= S_POST;
              post_rem <= post_clamped;
            end
          end
        end
        S_POST: begin
          if (wr_en) begin
            post_rem <= post_rem - ONE_W;
            if (post_rem == ONE_W) state <= S_DONE;
          end
        end
        S_DONE: begin
          if (start) begin
            state   <= S_CAPT;
            wr_ptr  <= '0;
            wrapped <= 1'b0;
            full    <= 1'b0;
`ifdef CAPTURE_DECIM_EN
            decim_cnt <= 8'd0;
`endif
          end else if (rd_start && (sample_cnt != '0)) begin
            state  <= S_RD_REQ;
            rd_ptr <= wrapped ? wr_ptr : '0;
            rd_rem <= sample_cnt;
          end
        end
        S_RD_REQ: begin
          state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          rd_data  <= mem_rdata;
          rd_valid <= 1'b1;
          rd_last  <= (rd_rem == ONE_W);
          state    <= S_RD_OUT;
        end
        S_RD_OUT: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_ptr   <= rd_ptr + 1'b1;
            rd_rem   <= rd_rem - ONE_W;
            state    <= (rd_rem == ONE_W) ? S_DONE : S_RD_REQ;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_capture_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_capture_mem_ctrl
// Brief    : Scoreboard bench for capture_mem_ctrl with a 1-cycle SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_capture_mem_ctrl;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int W      = NUM_CH * DATA_W;
  localparam int BW     = 2*NUM_CH + NUM_CH*ADDR_W + W;
  localparam int RW     = 2 + W + 3 + (ADDR_W+1) + BW;

  localparam logic [BW-1:0] NO_ACC = {{2*NUM_CH{1'b1}}, {(BW-2*NUM_CH){1'b0}}};
  localparam logic [RW-1:0] RST_VEC = {{(2+W+3+ADDR_W+1){1'b0}}, NO_ACC};

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     cfg_mode = 1'b0;
  logic [ADDR_W:0]          cfg_post_cnt = '0;
`ifdef CAPTURE_DECIM_EN
  logic [7:0]               cfg_decim = 8'd0;
`endif
  logic                     start = 1'b0;
  logic                     abort = 1'b0;
  logic                     trig = 1'b0;
  logic                     adc_valid = 1'b0;
  logic [W-1:0]             adc_data = '0;
  logic                     rd_start = 1'b0;
  logic                     rd_valid;
  logic                     rd_ready = 1'b1;
  logic [W-1:0]             rd_data;
  logic                     rd_last;
  logic                     busy;
  logic                     done;
  logic                     wrapped;
  logic [ADDR_W:0]          sample_cnt;
  logic [NUM_CH-1:0]        mem_cen;
  logic [NUM_CH-1:0]        mem_wen;
  logic [NUM_CH*ADDR_W-1:0] mem_addr;
  logic [W-1:0]             mem_wdata;
  logic [W-1:0]             mem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BW-1:0] wq[$];
  logic [W-1:0]  rq[$];
  logic [W-1:0]  sram [DEPTH];

  capture_mem_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_post_cnt(cfg_post_cnt),
`ifdef CAPTURE_DECIM_EN
    .cfg_decim(cfg_decim),
`endif
    .start(start), .abort(abort), .trig(trig), .adc_valid(adc_valid),
    .adc_data(adc_data), .rd_start(rd_start), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last), .busy(busy),
    .done(done), .wrapped(wrapped), .sample_cnt(sample_cnt), .mem_cen(mem_cen),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port SRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_cen[0] == 1'b0) begin
      if (mem_wen[0] == 1'b0) sram[mem_addr[ADDR_W-1:0]] <= mem_wdata;
      else                    mem_rdata <= sram[mem_addr[ADDR_W-1:0]];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {b, b + 8'd100, ~b};
  endfunction

  function automatic logic [BW-1:0] wr_vec(input int a, input int v);
    logic [ADDR_W-1:0] ad;
    ad = a[ADDR_W-1:0];
    return {{NUM_CH{1'b0}}, {NUM_CH{1'b0}}, {NUM_CH{ad}}, mk(v)};
  endfunction

  task automatic capture_sample(input int v, input logic t, input logic exp_wr, input int addr);
    logic [BW-1:0] obs, exp;
    @(negedge clk);
    adc_valid = 1'b1;
    adc_data  = mk(v);
    trig      = t;
    wq.push_back(exp_wr ? wr_vec(addr, v) : NO_ACC);
    #1;
    obs = {mem_cen, mem_wen, mem_addr, mem_wdata};
    exp = wq.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL mem_access v=%0d: got %h required %h", v, obs, exp);
    end
  endtask

  task automatic go_idle_inputs();
    @(negedge clk);
    adc_valid = 1'b0;
    trig      = 1'b0;
    #1;
  endtask

  task automatic check_status(input string nm, input logic [3+ADDR_W:0] exp);
    logic [3+ADDR_W:0] obs;
    obs = {busy, done, wrapped, sample_cnt};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: busy/done/wrapped/sample_cnt got %b required %b", nm, obs, exp);
    end
  endtask

  task automatic do_start(input logic mode, input logic [ADDR_W:0] post);
    @(negedge clk);
    cfg_mode     = mode;
    cfg_post_cnt = post;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_status("start_clears", {1'b1, 1'b0, 1'b0, {(ADDR_W+1){1'b0}}});
  endtask

  task automatic do_readout(input int n, input int stall_at, input string nm);
    int lat;
    logic [W-1:0] e;
    @(negedge clk);
    rd_ready = 1'b1;
    rd_start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      rd_start = 1'b0;
      lat++;
    end while (rd_valid !== 1'b1 && lat < 20);
    n_checks++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles required 3", nm, lat);
    end
    for (int i = 0; i < n; i++) begin
      int to;
      to = 0;
      while (rd_valid !== 1'b1 && to < 20) begin
        @(negedge clk);
        to++;
      end
      if (rd_valid !== 1'b1 || rq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_timeout: word %0d rd_valid=%b queue=%0d required valid word", nm, i, rd_valid, rq.size());
        rq.delete();
        return;
      end
      e = rq.pop_front();
      if (i == stall_at) begin
        rd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          n_checks++;
          if ({rd_valid, rd_data, mem_cen} !== {1'b1, e, {NUM_CH{1'b1}}}) begin
            n_fail++;
            $display("FAIL %s_stall: cycle %0d valid/data/cen got %b/%h/%b required 1/%h/111",
                     nm, k, rd_valid, rd_data, mem_cen, e);
          end
        end
        rd_ready = 1'b1;
      end
      n_checks++;
      if ({rd_valid, rd_data, rd_last} !== {1'b1, e, (i == n-1)}) begin
        n_fail++;
        $display("FAIL %s_word%0d: valid/data/last got %b/%h/%b required 1/%h/%b",
                 nm, i, rd_valid, rd_data, rd_last, e, (i == n-1));
      end
      @(negedge clk);
    end
    n_checks++;
    if ({done, rd_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL %s_end: done/valid/busy got %b%b%b required 100", nm, done, rd_valid, busy);
    end
    rq.delete();
  endtask

  task automatic test_reset();
    logic [RW-1:0] obs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    obs = {rd_valid, rd_last, rd_data, done, busy, wrapped, sample_cnt,
           mem_cen, mem_wen, mem_addr, mem_wdata};
    n_checks++;
    if (obs !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_values: got %h required %h", obs, RST_VEC);
    end
    rst = 1'b0;
  endtask

  task automatic test_oneshot();
    do_start(1'b0, 5'd0);
    for (int i = 0; i < 16; i++) capture_sample(i, 1'b0, 1'b1, i);
    go_idle_inputs();
    check_status("oneshot_done", {1'b0, 1'b1, 1'b0, 5'd16});
    capture_sample(77, 1'b1, 1'b0, 0);
    go_idle_inputs();
    for (int i = 0; i < 16; i++) rq.push_back(mk(i));
    do_readout(16, 5, "oneshot_rd");
  endtask

  task automatic test_ring();
    do_start(1'b1, 5'd4);
    for (int i = 0; i < 23; i++) capture_sample(i, (i == 19), 1'b1, i % DEPTH);
    go_idle_inputs();
    check_status("ring_post_pending", {1'b1, 1'b0, 1'b1, 5'd16});
    capture_sample(23, 1'b0, 1'b1, 23 % DEPTH);
    go_idle_inputs();
    check_status("ring_done", {1'b0, 1'b1, 1'b1, 5'd16});
    for (int i = 8; i < 24; i++) rq.push_back(mk(i));
    do_readout(16, -1, "ring_rd");
    for (int i = 8; i < 24; i++) rq.push_back(mk(i));
    do_readout(16, 2, "ring_rd_again");
  endtask

  task automatic test_post_clamp();
    do_start(1'b1, 5'd31);
    for (int i = 0; i < 17; i++) capture_sample(i + 100, (i == 1), 1'b1, i % DEPTH);
    go_idle_inputs();
    check_status("clamp_pending", {1'b1, 1'b0, 1'b1, 5'd16});
    capture_sample(117, 1'b0, 1'b1, 17 % DEPTH);
    go_idle_inputs();
    check_status("clamp_done", {1'b0, 1'b1, 1'b1, 5'd16});
  endtask

  task automatic test_post_zero();
    do_start(1'b1, 5'd0);
    for (int i = 0; i < 3; i++) capture_sample(50 + i, 1'b0, 1'b1, i);
    @(negedge clk);
    adc_valid = 1'b0;
    trig      = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    check_status("post_zero_done", {1'b0, 1'b1, 1'b0, 5'd3});
    capture_sample(99, 1'b0, 1'b0, 0);
    go_idle_inputs();
    check_status("post_zero_no_write", {1'b0, 1'b1, 1'b0, 5'd3});
    for (int i = 0; i < 3; i++) rq.push_back(mk(50 + i));
    do_readout(3, -1, "post_zero_rd");
  endtask

  task automatic test_abort();
    int to;
    @(negedge clk);
    rd_ready = 1'b0;
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    to = 0;
    while (rd_valid !== 1'b1 && to < 20) begin
      @(negedge clk);
      to++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    rd_ready = 1'b1;
    n_checks++;
    if ({rd_valid, rd_last, done, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_rd_out: valid/last/done/busy got %b%b%b%b required 0000",
               rd_valid, rd_last, done, busy);
    end
    check_status("abort_keeps_count", {1'b0, 1'b0, 1'b0, 5'd3});
    @(negedge clk);
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    @(negedge clk);
    check_status("rd_start_in_idle", {1'b0, 1'b0, 1'b0, 5'd3});
  endtask

  task automatic test_rst_post();
    logic [RW-1:0] obs;
    do_start(1'b1, 5'd4);
    for (int i = 0; i < 4; i++) capture_sample(i + 200, (i == 2), 1'b1, i);
    go_idle_inputs();
    check_status("rst_pre_post", {1'b1, 1'b0, 1'b0, 5'd4});
    @(negedge clk);
    rst       = 1'b1;
    adc_valid = 1'b1;
    @(negedge clk);
    obs = {rd_valid, rd_last, rd_data, done, busy, wrapped, sample_cnt,
           mem_cen, mem_wen, mem_addr, mem_wdata};
    n_checks++;
    if (obs !== RST_VEC) begin
      n_fail++;
      $display("FAIL rst_in_post: got %h required %h", obs, RST_VEC);
    end
    rst       = 1'b0;
    adc_valid = 1'b0;
  endtask

`ifdef CAPTURE_DECIM_EN
  task automatic test_decim();
    cfg_decim = 8'd2;
    do_start(1'b0, 5'd0);
    for (int i = 0; i < 12; i++) capture_sample(i, 1'b0, (i % 3 == 0), i / 3);
    go_idle_inputs();
    check_status("decim_count", {1'b1, 1'b0, 1'b0, 5'd4});
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort     = 1'b0;
    cfg_decim = 8'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_oneshot();
    test_ring();
    test_post_clamp();
    test_post_zero();
    test_abort();
    test_rst_post();
`ifdef CAPTURE_DECIM_EN
    test_decim();
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
